// File: rtl/sbox_share_arb.sv
// sbox_share_arb: round-robin arbiter that time-shares one 16-byte SubBytes
// block between the cipher datapath (port A) and key expansion (port B).
// Each lookup takes IDLE -> LOOKUP -> DONE, so one result is returned every
// three cycles. The ack pulses during DONE.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | sample req_a/req_b, latch the winner's operand into in_reg
// LOOKUP | in_reg drives the S-box; capture its output for the owner
// DONE   | ack to the owner; requester may drop or renew its request
module sbox_share_arb (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         req_a,
    input  logic [127:0] data_a,
    output logic         ack_a,
    output logic [127:0] result_a,
    input  logic         req_b,
    input  logic [127:0] data_b,
    output logic         ack_b,
    output logic [127:0] result_b,
    output logic [127:0] sbox_in,
    input  logic [127:0] sbox_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t         state_q, state_d;
    logic   [127:0] in_reg_q, in_reg_d;
    logic           owner_q, owner_d;
    logic           last_grant_q, last_grant_d;
    logic   [127:0] result_a_q, result_a_d;
    logic   [127:0] result_b_q, result_b_d;
    logic           ack_a_q, ack_a_d;
    logic           ack_b_q, ack_b_d;
    logic           grant_b;

    // State, operand, ownership, results and ack pulses; reset aborts any lookup.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            in_reg_q     <= '0;
            owner_q      <= PORT_A;
            last_grant_q <= PORT_B;
            result_a_q   <= '0;
            result_b_q   <= '0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_reg_q     <= in_reg_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            result_a_q   <= result_a_d;
            result_b_q   <= result_b_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
        end
    end

    // Next-state: arbitrate in IDLE, capture the S-box result at the end of LOOKUP.
    always_comb begin
        state_d      = state_q;
        in_reg_d     = in_reg_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        result_a_d   = result_a_q;
        result_b_d   = result_b_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        grant_b      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    // B wins when alone, or under contention when A had the last turn.
                    grant_b      = req_b && (!req_a || (last_grant_q == PORT_A));
                    in_reg_d     = grant_b ? data_b : data_a;
                    owner_d      = grant_b;
                    last_grant_d = grant_b;
                    state_d      = LOOKUP;
                end
            end
            LOOKUP: begin
                if (owner_q == PORT_B) begin
                    result_b_d = sbox_out;
                    ack_b_d    = 1'b1;
                end else begin
                    result_a_d = sbox_out;
                    ack_a_d    = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sbox_in  = in_reg_q;
    assign ack_a    = ack_a_q;
    assign ack_b    = ack_b_q;
    assign result_a = result_a_q;
    assign result_b = result_b_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_share_arb.sv
// Bench for sbox_share_arb: models the shared S-box, keeps a scoreboard of
// expected acks (port, result, cycle) and checks them as acks appear.
module tb_sbox_share_arb;

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct {
        logic         port;
        logic [127:0] value;
        int           cycle;
    } exp_t;

    logic         clk;
    logic         n_rst;
    logic         req_a, req_b;
    logic [127:0] data_a, data_b;
    logic         ack_a, ack_b;
    logic [127:0] result_a, result_b;
    logic [127:0] sbox_in, sbox_out;
    logic         busy;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    exp_t         sb_q[$];
    logic [127:0] shadow_a = '0;
    logic [127:0] shadow_b = '0;
    logic         prev_ack_a = 1'b0;
    logic         prev_ack_b = 1'b0;

    sbox_share_arb dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .req_a    (req_a),
        .data_a   (data_a),
        .ack_a    (ack_a),
        .result_a (result_a),
        .req_b    (req_b),
        .data_b   (data_b),
        .ack_b    (ack_b),
        .result_b (result_b),
        .sbox_in  (sbox_in),
        .sbox_out (sbox_out),
        .busy     (busy)
    );

    function automatic logic [7:0] s_lut(input logic [7:0] x);
        return SBOX_FLAT[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] d);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = s_lut(d[8*i +: 8]);
        return r;
    endfunction

    // Shared S-box instance stand-in: purely combinational.
    always_comb begin
        sbox_out = '0;
        for (int i = 0; i < 16; i++) sbox_out[8*i +: 8] = s_lut(sbox_in[8*i +: 8]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Ack monitor: pops the scoreboard on every ack and checks port, timing, data.
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_ack_a = 1'b0;
            prev_ack_b = 1'b0;
        end else begin
            if (ack_a || ack_b) begin
                exp_t e;
                check("ack_exclusive", ack_a & ack_b, 0);
                if (ack_a) check("ack_a_width", prev_ack_a, 0);
                if (ack_b) check("ack_b_width", prev_ack_b, 0);
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", {ack_a, ack_b}, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_port", ack_b, e.port);
                    check("ack_cycle", cyc, e.cycle);
                    if (e.port) begin
                        check("result_b", result_b, e.value);
                        check("result_a_hold", result_a, shadow_a);
                        shadow_b = e.value;
                    end else begin
                        check("result_a", result_a, e.value);
                        check("result_b_hold", result_b, shadow_b);
                        shadow_a = e.value;
                    end
                end
            end
            prev_ack_a = ack_a;
            prev_ack_b = ack_b;
        end
    end

    task automatic push(input logic port, input logic [127:0] value, input int delta);
        exp_t e;
        e.port  = port;
        e.value = value;
        e.cycle = cyc + delta;
        sb_q.push_back(e);
    endtask

    // Wait (bounded) until every expected ack has been seen.
    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        check(tag, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        logic [127:0] v;
        n_rst  = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = '0;
        data_b = '0;
        repeat (3) @(negedge clk);
        check("rst_ack_a", ack_a, 0);
        check("rst_ack_b", ack_b, 0);
        check("rst_result_a", result_a, 0);
        check("rst_result_b", result_b, 0);
        check("rst_sbox_in", sbox_in, 0);
        check("rst_busy", busy, 0);
        n_rst = 1'b1;

        // Single-port A with the standard test vector.
        @(negedge clk);
        data_a = 128'h00112233445566778899aabbccddeeff;
        req_a  = 1'b1;
        push(1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816, 2);
        @(posedge clk); #1;
        check("a_busy", busy, 1);
        check("a_sbox_in", sbox_in, 128'h00112233445566778899aabbccddeeff);
        drain("drain_single_a");
        req_a = 1'b0;

        // Single-port B: all zeros then all ones.
        @(negedge clk);
        data_b = '0;
        req_b  = 1'b1;
        push(1'b1, {16{8'h63}}, 2);
        drain("drain_b_zero");
        req_b = 1'b0;
        @(negedge clk);
        data_b = {16{8'hff}};
        req_b  = 1'b1;
        push(1'b1, {16{8'h16}}, 2);
        drain("drain_b_ones");
        req_b = 1'b0;

        // Request withdrawn before any sampling edge: nothing happens.
        @(negedge clk); @(negedge clk);
        #1 req_b = 1'b1;
        #1 req_b = 1'b0;
        repeat (4) @(negedge clk);
        check("withdraw_busy", busy, 0);

        // Contention from reset: A first, then strict alternation.
        n_rst    = 1'b0;
        shadow_a = '0;
        shadow_b = '0;
        data_a   = {16{8'h01}};
        data_b   = {16{8'h53}};
        req_a    = 1'b1;
        req_b    = 1'b1;
        @(negedge clk);
        n_rst = 1'b1;
        push(1'b0, {16{8'h7c}}, 2);
        push(1'b1, {16{8'hed}}, 5);
        push(1'b0, {16{8'h7c}}, 8);
        push(1'b1, {16{8'hed}}, 11);
        drain("drain_contention");
        req_a = 1'b0;
        req_b = 1'b0;

        // Mid-operation reset during LOOKUP aborts the lookup.
        @(negedge clk); @(negedge clk);
        data_a = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
        req_a  = 1'b1;
        @(posedge clk); #2;
        check("midrst_lookup_busy", busy, 1);
        n_rst = 1'b0;
        #1;
        check("midrst_ack_a", ack_a, 0);
        check("midrst_result_a", result_a, 0);
        check("midrst_result_b", result_b, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sbox_in", sbox_in, 0);
        req_a    = 1'b0;
        shadow_a = '0;
        shadow_b = '0;
        @(negedge clk); @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        v      = {$urandom, $urandom, $urandom, $urandom};
        data_a = v;
        req_a  = 1'b1;
        push(1'b0, sub_bytes(v), 2);
        drain("drain_after_rst");
        req_a = 1'b0;

        // Operand change right after the grant is ignored.
        @(negedge clk);
        v      = {$urandom, $urandom, $urandom, $urandom};
        data_a = v;
        req_a  = 1'b1;
        push(1'b0, sub_bytes(v), 2);
        @(posedge clk); #1;
        data_a = ~v;
        check("stable_sbox_in", sbox_in, v);
        drain("drain_stability");
        req_a = 1'b0;

        // A few random single requests on alternating ports.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v = {$urandom, $urandom, $urandom, $urandom};
            if (i % 2 == 0) begin
                data_b = v;
                req_b  = 1'b1;
            end else begin
                data_a = v;
                req_a  = 1'b1;
            end
            push(i % 2 == 0, sub_bytes(v), 2);
            drain("drain_random");
            req_a = 1'b0;
            req_b = 1'b0;
        end

        repeat (4) @(negedge clk);
        check("final_busy", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
